gate_sweep_checker: RTL

Synthesizable self-checking stimulus engine for small combinational gate networks: it drives every input vector of an N-input gate under test, waits a programmable settle time, samples the gate output and compares it against a latched expected truth table. It replaces hand-written per-gate testbenches, which apply four vectors and print results, with a clocked sweep that reports pass/fail and a per-vector failure mask. It sits between a control/testbench host and one gate instance, such as the NAND-built OR.

---
 rtl/gate_sweep_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector of an N_IN-input gate, samples it after SETTLE extra cycles, and compares against a latched truth table.
// Optional GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatching vector.
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2**N_IN-1:0] expect_tbl_i,
    output logic [N_IN-1:0]    dut_in_o,
    input  logic               dut_out_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [2**N_IN-1:0] fail_mask_o,
    output logic [N_IN:0]      err_count_o
);
    localparam int NV = 2**N_IN;
    localparam logic [N_IN:0] ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};
    localparam logic [3:0]    SET  = SETTLE[3:0];
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   vec_q, vec_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic [NV-1:0]   mask_q, mask_d;
    logic [N_IN:0]   err_q, err_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            sample, mism, last;

    assign sample = cnt_q == SET;
    // Case inequality so an X/Z gate output counts as a mismatch
    assign mism   = dut_out_i !== exp_q[vec_q[N_IN-1:0]];
    assign last   = (vec_q == LAST) || (STOP && mism);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        err_d   = err_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start_i) begin
                state_d = RUN;
                exp_d   = expect_tbl_i;
                mask_d  = '0;
                err_d   = '0;
                pass_d  = 1'b0;
                vec_d   = '0;
                cnt_d   = '0;
            end
        end else if (!sample) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            if (mism) begin
                mask_d[vec_q[N_IN-1:0]] = 1'b1;
                err_d = err_q + ONE;
            end
            cnt_d = '0;
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
                pass_d  = err_d == '0;
            end else begin
                vec_d = vec_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign dut_in_o    = vec_q[N_IN-1:0];
    assign busy_o      = state_q == RUN;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_mask_o = mask_q;
    assign err_count_o = err_q;
endmodule
